// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the digit-serial subtractor.
// The requester drives start and the operands. The subtractor returns status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic             overflow;

    modport master (
        output start, A, B, bin,
        input  busy, done, diff, borrow_out, zero, overflow
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, diff, borrow_out, zero, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: computes A - B - bin one DIGIT-wide slice per cycle, least significant first.
// The borrow ripples between cycles, so no carry path is wider than one digit.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    serial_subtractor_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DW    = DIGIT + 1;
    localparam logic [KW-1:0] LAST_K = KW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
    logic             borrow_q;
    logic             accept;
    logic [DW-1:0]    d;

    logic             busy_q, done_q, borrow_out_q, zero_q, overflow_q;
    logic [WIDTH-1:0] diff_q;

    // NOTE: every variable written in always_comb gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept   = 1'b1;
                state_nx = RUN;
            end
            RUN:  if (k == LAST_K) state_nx = DONE;
            DONE: begin
                accept   = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        d = {1'b0, a_q[int'(k)*DIGIT +: DIGIT]}
          - {1'b0, b_q[int'(k)*DIGIT +: DIGIT]}
          - DW'(borrow_q);
        res_nx = res_q;
        res_nx[int'(k)*DIGIT +: DIGIT] = d[DIGIT-1:0];
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: operand and result registers are reset too, because a reset must leave no trace of a previous operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            k            <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
            if (accept) begin
                a_q      <= bus.A;
                b_q      <= bus.B;
                borrow_q <= bus.bin;
                k        <= '0;
            end else if (state == RUN) begin
                res_q    <= res_nx;
                borrow_q <= d[DIGIT];
                k        <= k + KW'(1);
                if (k == LAST_K) begin
                    diff_q       <= res_nx;
                    borrow_out_q <= d[DIGIT];
                    zero_q       <= (res_nx == '0);
                    overflow_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors covering timing, flags, handshake and reset behaviour.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(16)) bus ();

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b, input logic bi);
        bus.start = s;
        bus.A     = a;
        bus.B     = b;
        bus.bin   = bi;
    endtask

    task automatic check_results(input string tag, input logic [15:0] d, input logic bo,
                                 input logic z, input logic ov);
        check({tag, " diff"},     32'(bus.diff),       32'(d));
        check({tag, " borrow"},   32'(bus.borrow_out), 32'(bo));
        check({tag, " zero"},     32'(bus.zero),       32'(z));
        check({tag, " overflow"}, 32'(bus.overflow),   32'(ov));
    endtask

    // Full operation from an idle start: busy for 4 cycles after E0, done for one cycle after E4.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [15:0] d, input logic bo, input logic z, input logic ov);
        drive(1'b1, a, b, bi);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " early done"}, 32'(bus.done), 32'd0);
            step();
        end
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        check_results(tag, d, bo, z, ov);
        step();
        check({tag, " done cleared"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check_results("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf_pos", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op("ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        run_op("bin_zero", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Start while busy must be ignored; then chain a new operation from the done cycle.
        drive(1'b1, 16'h0010, 16'h0001, 1'b0);
        step();                                   // E0
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        step();                                   // E1
        drive(1'b1, 16'hFFFF, 16'h1234, 1'b1);
        step();                                   // E2
        step();                                   // E3
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        step();                                   // E4
        check("hs done", 32'(bus.done), 32'd1);
        check_results("hs first", 16'h000F, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0003, 16'h0005, 1'b0);
        step();                                   // E5
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("b2b busy", 32'(bus.busy), 32'd1);
            check("b2b done low", 32'(bus.done), 32'd0);
            check("b2b diff hold", 32'(bus.diff), 32'h000F);
            step();                               // E6..E9
        end
        check("b2b done", 32'(bus.done), 32'd1);
        check_results("b2b", 16'hFFFE, 1'b1, 1'b0, 1'b0);
        step();
        check("b2b done cleared", 32'(bus.done), 32'd0);
        check("b2b idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of an operation aborts it.
        drive(1'b1, 16'h1234, 16'h0001, 1'b0);
        step();                                   // E0
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        step();                                   // E1
        reset = 1'b1;
        step();                                   // E2 with reset
        reset = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check_results("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort no done", 32'(bus.done), 32'd0);
        end
        run_op("after_abort", 16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0);

        // Reset and start at the same edge: start is dropped.
        reset = 1'b1;
        drive(1'b1, 16'h0005, 16'h0001, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("collide busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("collide no done", 32'(bus.done), 32'd0);
            check("collide idle", 32'(bus.busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
